rotate_image: RTL and testbench



---
 rtl/rotate_image.sv | 217 +++++++++++++++++++++
 tb/tb_rotate_image.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotate_image.sv
// rotate_image: inverse-mapping source coordinate for image rotation.
// Rotates pixel (i_H, i_V) about the image centre by i_angle degrees with an
// iterative CORDIC engine, one micro-rotation per clock.
// Optional feature macro: ROTATE_OOR_CLAMP_EN (clamp out-of-range results
// into the image instead of zeroing them).
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for i_start; captures H, V and angle
//   PREP  | centre coordinates, normalise angle, fold into [-90, 90]
//   ITER  | one CORDIC micro-rotation per cycle, ITERATIONS cycles
//   POST  | gain correction, re-centre, round, range check, pulse o_done
module rotate_image #(
  parameter int IMAGE_SIZE     = 60,
  parameter int IMAGE_COOR_BIT = 7,
  parameter int ANG_WIDTH      = 9,
  parameter int ITERATIONS     = 12
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic [IMAGE_COOR_BIT-1:0]   i_H,
  input  logic [IMAGE_COOR_BIT-1:0]   i_V,
  input  logic signed [ANG_WIDTH-1:0] i_angle,
  output logic [IMAGE_COOR_BIT-1:0]   o_H,
  output logic [IMAGE_COOR_BIT-1:0]   o_V,
  output logic                        o_done,
  output logic                        o_outOfRange
);

  localparam int C     = IMAGE_SIZE / 2;
  localparam int FRAC  = 8;              // fractional bits of angle and of the loaded dx/dy
  localparam int GUARD = 6;              // extra low bits in x/y to keep shift truncation small
  localparam int XF    = FRAC + GUARD;   // fractional bits carried by x/y
  // Integer part: coordinate magnitude, sqrt(2) vector growth, CORDIC gain 1.65, sign.
  localparam int XW    = IMAGE_COOR_BIT + 4 + XF;
  localparam int AW    = ANG_WIDTH + 2;  // holds angle +/- 360 without overflow
  localparam int ZW    = AW + FRAC;
  localparam int IW    = $clog2(ITERATIONS + 1);
  localparam int PW    = XW + 17;        // x/y times a Q1.15 constant
  localparam int PSH   = XF + 15;        // fractional bits of the product

  localparam logic [IW-1:0]        LAST_ITER = IW'(ITERATIONS - 1);
  localparam logic signed [XW-1:0] C_X       = XW'(C);
  localparam logic signed [AW-1:0] D90       = AW'(90);
  localparam logic signed [AW-1:0] D90_N     = -AW'(90);
  localparam logic signed [AW-1:0] D180      = AW'(180);
  localparam logic signed [AW-1:0] D180_N    = -AW'(180);
  localparam logic signed [AW-1:0] D360      = AW'(360);
  localparam logic signed [16:0]   K_Q15     = 17'sd19898;
  // Adds the centre back and the +0.5 rounding term in product scale.
  localparam logic signed [PW-1:0] POST_OFF  = (PW'(C) <<< PSH) + (PW'(1) <<< (PSH - 1));
  localparam logic signed [PW-1:0] SIZE_P    = PW'(IMAGE_SIZE);
`ifdef ROTATE_OOR_CLAMP_EN
  localparam logic [IMAGE_COOR_BIT-1:0] MAX_COOR = IMAGE_COOR_BIT'(IMAGE_SIZE - 1);
`endif

  typedef enum logic [1:0] {IDLE, PREP, ITER, POST} state_t;

  state_t                      state;
  logic [IMAGE_COOR_BIT-1:0]   h_q, v_q;
  logic signed [ANG_WIDTH-1:0] ang_q;
  logic signed [XW-1:0]        x_q, y_q;
  logic signed [ZW-1:0]        z_q;
  logic [IW-1:0]               iter;

  // atan(2^-i) in degrees, 8 fractional bits, rounded to nearest.
  function automatic logic signed [ZW-1:0] atan_lut(input int idx);
    case (idx)
      0:       atan_lut = ZW'(11520);
      1:       atan_lut = ZW'(6801);
      2:       atan_lut = ZW'(3593);
      3:       atan_lut = ZW'(1824);
      4:       atan_lut = ZW'(916);
      5:       atan_lut = ZW'(458);
      6:       atan_lut = ZW'(229);
      7:       atan_lut = ZW'(115);
      8:       atan_lut = ZW'(57);
      9:       atan_lut = ZW'(29);
      10:      atan_lut = ZW'(14);
      11:      atan_lut = ZW'(7);
      12:      atan_lut = ZW'(4);
      13:      atan_lut = ZW'(2);
      14:      atan_lut = ZW'(1);
      default: atan_lut = '0;
    endcase
  endfunction

  logic signed [AW-1:0] ang_ext, ang_wrap, ang_res;
  logic signed [ZW-1:0] z_ext, z_init;
  logic signed [XW-1:0] dx_fx, dy_fx, x_init, y_init;

  // Preparation: centred fixed-point vector and residual angle in [-90, 90].
  always_comb begin
    ang_ext  = {{2{ang_q[ANG_WIDTH-1]}}, ang_q};
    ang_wrap = ang_ext;
    if (ang_ext > D180)
      ang_wrap = ang_ext - D360;
    else if (ang_ext <= D180_N)
      ang_wrap = ang_ext + D360;
    dx_fx = XW'(h_q);
    dx_fx = (dx_fx - C_X) <<< XF;
    dy_fx = XW'(v_q);
    dy_fx = (dy_fx - C_X) <<< XF;
    ang_res = ang_wrap;
    x_init  = dx_fx;
    y_init  = dy_fx;
    // A half-turn is absorbed by negating the vector.
    if (ang_wrap > D90) begin
      ang_res = ang_wrap - D180;
      x_init  = -dx_fx;
      y_init  = -dy_fx;
    end else if (ang_wrap < D90_N) begin
      ang_res = ang_wrap + D180;
      x_init  = -dx_fx;
      y_init  = -dy_fx;
    end
    z_ext  = {{(ZW-AW){ang_res[AW-1]}}, ang_res};
    z_init = z_ext <<< FRAC;
  end

  logic signed [XW-1:0] x_sh, y_sh;
  logic signed [ZW-1:0] atan_i;

  // Micro-rotation operands for the current iteration.
  always_comb begin
    x_sh   = x_q >>> iter;
    y_sh   = y_q >>> iter;
    atan_i = atan_lut(int'(iter));
  end

  logic signed [PW-1:0]      px, py, h_full, v_full;
  logic                      h_oor, v_oor, oor;
  logic [IMAGE_COOR_BIT-1:0] h_out, v_out;

  // Post-processing: gain correction, re-centre, round, range check.
  always_comb begin
    px     = PW'(x_q) * PW'(K_Q15);
    py     = PW'(y_q) * PW'(K_Q15);
    h_full = (px + POST_OFF) >>> PSH;
    v_full = (py + POST_OFF) >>> PSH;
    h_oor  = h_full[PW-1] || (h_full >= SIZE_P);
    v_oor  = v_full[PW-1] || (v_full >= SIZE_P);
    oor    = h_oor || v_oor;
`ifdef ROTATE_OOR_CLAMP_EN
    if (h_full[PW-1])      h_out = '0;
    else if (h_oor)        h_out = MAX_COOR;
    else                   h_out = h_full[IMAGE_COOR_BIT-1:0];
    if (v_full[PW-1])      v_out = '0;
    else if (v_oor)        v_out = MAX_COOR;
    else                   v_out = v_full[IMAGE_COOR_BIT-1:0];
`else
    h_out = oor ? '0 : h_full[IMAGE_COOR_BIT-1:0];
    v_out = oor ? '0 : v_full[IMAGE_COOR_BIT-1:0];
`endif
  end

  // Sequencer and datapath registers; outputs hold until the next result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      h_q          <= '0;
      v_q          <= '0;
      ang_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      z_q          <= '0;
      iter         <= '0;
      o_H          <= '0;
      o_V          <= '0;
      o_done       <= 1'b0;
      o_outOfRange <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            h_q   <= i_H;
            v_q   <= i_V;
            ang_q <= i_angle;
            state <= PREP;
          end
        end
        PREP: begin
          x_q   <= x_init;
          y_q   <= y_init;
          z_q   <= z_init;
          iter  <= '0;
          state <= ITER;
        end
        ITER: begin
          if (!z_q[ZW-1]) begin
            x_q <= x_q - y_sh;
            y_q <= y_q + x_sh;
            z_q <= z_q - atan_i;
          end else begin
            x_q <= x_q + y_sh;
            y_q <= y_q - x_sh;
            z_q <= z_q + atan_i;
          end
          iter <= iter + 1'b1;
          if (iter == LAST_ITER)
            state <= POST;
        end
        POST: begin
          o_H          <= h_out;
          o_V          <= v_out;
          o_outOfRange <= oor;
          o_done       <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rotate_image.sv
// Self-checking bench for rotate_image: directed vectors plus random jobs
// compared against a floating-point rotation model.
module tb_rotate_image;

  localparam int SIZE    = 60;
  localparam int CEN     = SIZE / 2;
  localparam int LATENCY = 14;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [6:0]        h_in, v_in;
  logic signed [8:0] ang_in;
  logic [6:0]        h_out, v_out;
  logic              done, oor;

  int errors = 0;
  int checks = 0;

  rotate_image dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_H          (h_in),
    .i_V          (v_in),
    .i_angle      (ang_in),
    .o_H          (h_out),
    .o_V          (v_out),
    .o_done       (done),
    .o_outOfRange (oor)
  );

  always #5 clk = ~clk;

  // Ideal rotation about the centre; accepts +/-1 where the ideal value sits
  // within 1/32 of a rounding tie.
  function automatic bit model_ok(input int h, input int v, input int a,
                                  input logic [6:0] gh, input logic [6:0] gv,
                                  input logic go, output int nh, output int nv);
    real rad, dx, dy, xr, yr;
    bit  amb_h, amb_v, t_oor;
    int  th, tv, eh, ev;
    rad   = a * 3.14159265358979 / 180.0;
    dx    = h - CEN;
    dy    = v - CEN;
    xr    = dx * $cos(rad) - dy * $sin(rad) + CEN;
    yr    = dx * $sin(rad) + dy * $cos(rad) + CEN;
    nh    = int'($floor(xr + 0.5));
    nv    = int'($floor(yr + 0.5));
    amb_h = ((xr - $floor(xr)) - 0.5 <= 1.0/32) && (0.5 - (xr - $floor(xr)) <= 1.0/32);
    amb_v = ((yr - $floor(yr)) - 0.5 <= 1.0/32) && (0.5 - (yr - $floor(yr)) <= 1.0/32);
    model_ok = 1'b0;
    for (int dh = -1; dh <= 1; dh++) begin
      for (int dv = -1; dv <= 1; dv++) begin
        if ((dh == 0 || amb_h) && (dv == 0 || amb_v)) begin
          th    = nh + dh;
          tv    = nv + dv;
          t_oor = (th < 0) || (th >= SIZE) || (tv < 0) || (tv >= SIZE);
          eh    = th;
          ev    = tv;
          if (t_oor) begin
`ifdef ROTATE_OOR_CLAMP_EN
            eh = (th < 0) ? 0 : (th >= SIZE) ? SIZE - 1 : th;
            ev = (tv < 0) ? 0 : (tv >= SIZE) ? SIZE - 1 : tv;
`else
            eh = 0;
            ev = 0;
`endif
          end
          if (gh == 7'(eh) && gv == 7'(ev) && go == t_oor)
            model_ok = 1'b1;
        end
      end
    end
  endfunction

  // Issue one request with a single-cycle start; scramble inputs after capture.
  task automatic do_job(input int h, input int v, input int a,
                        output logic [6:0] rh, output logic [6:0] rv,
                        output logic ro, output int lat, output logic extra);
    @(negedge clk);
    start  = 1'b1;
    h_in   = 7'(h);
    v_in   = 7'(v);
    ang_in = 9'(a);
    @(posedge clk);
    #1;
    start  = 1'b0;
    h_in   = 7'($urandom);
    v_in   = 7'($urandom);
    ang_in = 9'($urandom);
    lat    = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = e;
        break;
      end
    end
    rh = h_out;
    rv = v_out;
    ro = oor;
    @(posedge clk);
    #1;
    extra = done;
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    start  = 1'b0;
    h_in   = '0;
    v_in   = '0;
    ang_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (h_out !== 7'd0 || v_out !== 7'd0 || done !== 1'b0 || oor !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got H=%0d V=%0d done=%b oor=%b, want all 0", h_out, v_out, done, oor);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_held_start;
    int pulses;
    int edges[$];
    @(negedge clk);
    start  = 1'b1;
    h_in   = 7'd0;
    v_in   = 7'd30;
    ang_in = 9'sd45;
    @(posedge clk);
    pulses = 0;
    for (int e = 1; e <= 44; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        edges.push_back(e);
        checks++;
        if (h_out !== 7'd9 || v_out !== 7'd9 || oor !== 1'b0) begin
          errors++;
          $display("FAIL held_value: edge %0d got H=%0d V=%0d oor=%b, want 9 9 0", e, h_out, v_out, oor);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (pulses !== 3) begin
      errors++;
      $display("FAIL held_pulse_count: got %0d pulses, want 3", pulses);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (edges[k] !== LATENCY + 15 * k) begin
          errors++;
          $display("FAIL held_pulse_edge: pulse %0d at edge %0d, want %0d", k, edges[k], LATENCY + 15 * k);
        end
      end
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_directed;
    int tab[6][6] = '{
      '{0, 30, 90, 30, 0, 0},
      '{0, 30, -45, 9, 51, 0},
      '{17, 42, 0, 17, 42, 0},
      '{0, 30, 104, 37, 1, 0},
      '{0, 30, -256, 37, 1, 0},
`ifdef ROTATE_OOR_CLAMP_EN
      '{0, 30, 180, 59, 30, 1}
`else
      '{0, 30, 180, 0, 0, 1}
`endif
    };
    logic [6:0] rh, rv;
    logic ro, extra;
    int lat;
    for (int k = 0; k < 6; k++) begin
      do_job(tab[k][0], tab[k][1], tab[k][2], rh, rv, ro, lat, extra);
      checks++;
      if (lat !== LATENCY || extra !== 1'b0) begin
        errors++;
        $display("FAIL directed_timing[%0d]: done at edge %0d second cycle=%b, want edge %0d single", k, lat, extra, LATENCY);
      end
      checks++;
      if (rh !== 7'(tab[k][3]) || rv !== 7'(tab[k][4]) || ro !== tab[k][5][0]) begin
        errors++;
        $display("FAIL directed_value[%0d]: angle %0d got H=%0d V=%0d oor=%b, want %0d %0d %0d",
                 k, tab[k][2], rh, rv, ro, tab[k][3], tab[k][4], tab[k][5]);
      end
    end
  endtask

  task automatic test_centre;
    int angs[8] = '{-256, -180, -1, 0, 1, 89, 91, 255};
    logic [6:0] rh, rv;
    logic ro, extra;
    int lat;
    foreach (angs[k]) begin
      do_job(CEN, CEN, angs[k], rh, rv, ro, lat, extra);
      checks++;
      if (rh !== 7'd30 || rv !== 7'd30 || ro !== 1'b0 || lat !== LATENCY) begin
        errors++;
        $display("FAIL centre: angle %0d got H=%0d V=%0d oor=%b lat=%0d, want 30 30 0 lat %0d",
                 angs[k], rh, rv, ro, lat, LATENCY);
      end
    end
  endtask

  task automatic test_random;
    logic [6:0] rh, rv;
    logic ro, extra;
    int lat, h, v, a, nh, nv;
    for (int k = 0; k < 60; k++) begin
      h = (k % 2 == 0) ? int'($urandom_range(0, SIZE - 1)) : int'($urandom_range(0, 127));
      v = (k % 3 == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, SIZE - 1));
      a = int'($urandom_range(0, 511)) - 256;
      do_job(h, v, a, rh, rv, ro, lat, extra);
      checks++;
      if (!model_ok(h, v, a, rh, rv, ro, nh, nv) || lat !== LATENCY || extra !== 1'b0) begin
        errors++;
        $display("FAIL random: H=%0d V=%0d a=%0d got H=%0d V=%0d oor=%b lat=%0d, want about %0d %0d lat %0d",
                 h, v, a, rh, rv, ro, lat, nh, nv, LATENCY);
      end
    end
  endtask

  task automatic test_busy_ignore;
    int first, count;
    logic [6:0] rh, rv;
    logic ro;
    @(negedge clk);
    start  = 1'b1;
    h_in   = 7'd0;
    v_in   = 7'd30;
    ang_in = -9'sd45;
    @(posedge clk);
    #1;
    start = 1'b0;
    first = -1;
    count = 0;
    rh = '0; rv = '0; ro = 1'b0;
    for (int e = 1; e <= 34; e++) begin
      @(posedge clk);
      #1;
      if (e == 2) begin
        start  = 1'b1;
        h_in   = 7'd17;
        v_in   = 7'd42;
        ang_in = 9'sd0;
      end
      if (e == 8)
        start = 1'b0;
      if (done) begin
        count++;
        if (first < 0) begin
          first = e;
          rh = h_out;
          rv = v_out;
          ro = oor;
        end
      end
    end
    checks++;
    if (count !== 1 || first !== LATENCY) begin
      errors++;
      $display("FAIL busy_ignore_timing: %0d pulses first at edge %0d, want 1 at edge %0d", count, first, LATENCY);
    end
    checks++;
    if (rh !== 7'd9 || rv !== 7'd51 || ro !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore_value: got H=%0d V=%0d oor=%b, want 9 51 0", rh, rv, ro);
    end
  endtask

  task automatic test_reset_abort;
    logic [6:0] rh, rv;
    logic ro, extra;
    int lat, count;
    do_job(0, 30, 45, rh, rv, ro, lat, extra);
    @(negedge clk);
    start  = 1'b1;
    h_in   = 7'd0;
    v_in   = 7'd30;
    ang_in = 9'sd90;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (h_out !== 7'd0 || v_out !== 7'd0 || done !== 1'b0 || oor !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: got H=%0d V=%0d done=%b oor=%b, want all 0", h_out, v_out, done, oor);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    count = 0;
    for (int e = 0; e < 25; e++) begin
      @(posedge clk);
      #1;
      if (done) count++;
    end
    checks++;
    if (count !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d pulses, want 0", count);
    end
    do_job(0, 30, 90, rh, rv, ro, lat, extra);
    checks++;
    if (rh !== 7'd30 || rv !== 7'd0 || ro !== 1'b0 || lat !== LATENCY) begin
      errors++;
      $display("FAIL abort_recover: got H=%0d V=%0d oor=%b lat=%0d, want 30 0 0 lat %0d", rh, rv, ro, lat, LATENCY);
    end
  endtask

  initial begin
    test_reset;
    test_held_start;
    test_directed;
    test_centre;
    test_busy_ignore;
    test_random;
    test_reset_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
